pipe_drawer: RTL and testbench
==============================

# pipe_drawer

Consumes the per-pipe coordinate pair (column x, gap-top y) produced by the pipe position logic and converts it into a pixel-write stream for the 160x120 VGA adapter. On every rising edge of the game clock it erases the rectangle it drew last time, then redraws the pipe at its new position with the opening left in background colour. It sits between the pipe registers and the VGA adapter plot port, one instance per pipe or time-shared by a top-level arbiter using `busy` and `done`.

## Interface
Parameters:
- `PIPE_W`, 4: pipe width in pixels (1–16).
- `GAP_H`, 30: opening height in pixels.
- `PIPE_COLOUR`, 3'b010: colour of pipe body.
- `BG_COLOUR`, 3'b000: background and erase colour.

Ports:
- `CLOCK_50` in 1: sole clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `game_clk` in 1: slow game tick, asynchronous to `CLOCK_50`.
- `pipe_x` in 9: pipe left column, 0–160.
- `pipe_y` in 7: top row of the opening.
- `vga_x` out 8: pixel column to plot.
- `vga_y` out 7: pixel row to plot.
- `colour` out 3: pixel colour.
- `plot` out 1: write strobe, one pixel per cycle when high.
- `busy` out 1: high from capture until `done` inclusive.
- `done` out 1: one-cycle pulse at end of a redraw.
- `overrun` out 1: sticky; a tick arrived while busy.

## Operation
- `game_clk` passes through a 2-flop synchroniser plus an edge register; `tick` = synchronised rising edge, one cycle wide.
- FSM states: IDLE, ERASE, DRAW, DONE.
- IDLE: on `tick`, capture `pipe_x`/`pipe_y` into `cur_x`/`cur_y`; go to ERASE if `prev_valid`, else DRAW.
- ERASE: scan row r = 0..119 (outer), col c = 0..PIPE_W-1 (inner); emit (`prev_x`+c, r) in `BG_COLOUR`.
- DRAW: same scan over `cur_x`; colour = `BG_COLOUR` if `cur_y` <= r < `cur_y`+`GAP_H` (8-bit compare, no wrap), else `PIPE_COLOUR`.
- Clipping: a pixel whose column (computed 9-bit, `x`+c) is >= 160 still consumes its cycle, with `plot`=0; `vga_x` takes the low 8 bits.
- DONE: `done`=1 for one cycle; `prev_x`<=`cur_x`, `prev_y`<=`cur_y`, `prev_valid`<=1; return to IDLE.
- `tick` while not IDLE: ignored for drawing, sets `overrun`; cleared only by `reset`.
- Inputs are sampled only on the capture cycle; later changes during a redraw have no effect.

## Timing
- Reset values: `vga_x`=0, `vga_y`=0, `colour`=0, `plot`=0, `busy`=0, `done`=0, `overrun`=0; FSM=IDLE, `prev_valid`=0, scan counters 0.
- `game_clk` rise to `tick`: 2–3 `CLOCK_50` cycles.
- Capture occurs on the `tick` cycle; `busy` rises the following cycle, together with the first pixel.
- All pixel outputs are registered; one pixel per cycle, no stalls.
- ERASE lasts 120·`PIPE_W` cycles, DRAW lasts 120·`PIPE_W` cycles, DONE lasts 1 cycle. With defaults: 481 cycles first redraw, 961 cycles thereafter.
- `busy` falls the cycle after `done`.
- Reset mid-redraw: next cycle all outputs at reset values, `prev_valid`=0; no partial erase is remembered.
- Wrap-around (x 0 -> 160): erase at x=0, draw at 160 fully clipped (`plot`=0 for all DRAW pixels).

## Configuration
- `PIPE_DRAWER_ERASE_EN` defined: ERASE state present as described.
- Undefined: ERASE omitted; IDLE always goes to DRAW; redraw takes 120·`PIPE_W`+1 cycles; `prev_*` registers removed; host clears the screen.

## Test plan
- Reset, then `game_clk` rise with x=50, y=40 -> no ERASE; 480 DRAW pixels at columns 50–53; rows 40–69 in colour 000, other rows 010; `done` at pixel count 480+1.
- Second tick with x=49, y=40 -> 480 erase pixels at columns 50–53 in colour 000, then DRAW at 49–52; `busy` high for 961 cycles.
- x=158 -> columns 158,159 have `plot`=1, columns 160,161 have `plot`=0; total cycle count is unchanged.
- x=0 then x=160, y=90 -> erase columns 0–3; DRAW has `plot`=0 throughout; gap rows 90–119 are clipped without wrap.
- Extra `game_clk` rise mid-DRAW -> `overrun`=1, redraw completes unchanged, no second redraw; `reset` -> `overrun`=0.
- `reset` asserted at DRAW pixel 100 -> next cycle `plot`=0, `busy`=0; next tick skips ERASE.

Source files
------------

// File: rtl/pipe_drawer.sv
// Purpose: turns a pipe (column, gap-top row) pair into a pixel-write stream for the 160x120 VGA plot port.
// Latency: busy and first pixel one cycle after the synchronised game tick; 120*PIPE_W pixels per scan, then a 1-cycle done.
// Backpressure: none -- one pixel per cycle, never stalls; ticks arriving while busy are dropped and flag overrun.
// Optional feature: define PIPE_DRAWER_ERASE_EN to erase the previously drawn column before each redraw.
module pipe_drawer #(
    parameter int         PIPE_W      = 4,
    parameter int         GAP_H       = 30,
    parameter logic [2:0] PIPE_COLOUR = 3'b010,
    parameter logic [2:0] BG_COLOUR   = 3'b000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       game_clk,
    input  logic [8:0] pipe_x,
    input  logic [6:0] pipe_y,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done,
    output logic       overrun
);

    localparam int CW = (PIPE_W > 1) ? $clog2(PIPE_W) : 1;

    typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_t;

    state_t        state, nxt_state;
    logic [6:0]    row, nxt_row;
    logic [CW-1:0] col, nxt_col;
    logic [8:0]    cur_x, nxt_cur_x;
    logic [6:0]    cur_y, nxt_cur_y;
    logic          sync1, sync2, sync3;
    logic          tick;
    logic          last_col, last_row;
    logic [8:0]    base_x;
    logic [8:0]    pix_col;
    logic          pix_on;
    logic          in_gap;

`ifdef PIPE_DRAWER_ERASE_EN
    // Only the column is remembered: the erase pass covers every row anyway.
    logic [8:0]    prev_x;
    logic          prev_valid;
`endif

    // Bring the slow game tick into CLOCK_50 and keep one stage for edge detection.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= game_clk;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign tick     = sync2 & ~sync3;
    assign last_col = (col == CW'(PIPE_W - 1));
    assign last_row = (row == 7'd119);

    // Next-state and scan-counter logic; also decides which pixel the output registers load next.
    always_comb begin
        nxt_state = state;
        nxt_row   = row;
        nxt_col   = col;
        nxt_cur_x = cur_x;
        nxt_cur_y = cur_y;
        case (state)
            IDLE: begin
                if (tick) begin
                    nxt_cur_x = pipe_x;
                    nxt_cur_y = pipe_y;
                    nxt_row   = 7'd0;
                    nxt_col   = '0;
`ifdef PIPE_DRAWER_ERASE_EN
                    nxt_state = prev_valid ? ERASE : DRAW;
`else
                    nxt_state = DRAW;
`endif
                end
            end
            ERASE, DRAW: begin
                if (last_col) begin
                    nxt_col = '0;
                    if (last_row) begin
                        nxt_row   = 7'd0;
                        nxt_state = (state == ERASE) ? DRAW : DONE;
                    end else begin
                        nxt_row = row + 7'd1;
                    end
                end else begin
                    nxt_col = col + CW'(1);
                end
            end
            DONE:    nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase
    end

    // Pixel for the upcoming cycle: column offset from the erase or draw base, gap test without wrap.
    always_comb begin
`ifdef PIPE_DRAWER_ERASE_EN
        base_x = (nxt_state == ERASE) ? prev_x : nxt_cur_x;
`else
        base_x = nxt_cur_x;
`endif
        pix_col = base_x + 9'(nxt_col);
        pix_on  = (nxt_state == ERASE) || (nxt_state == DRAW);
        in_gap  = ({1'b0, nxt_row} >= {1'b0, nxt_cur_y}) &&
                  ({1'b0, nxt_row} <  ({1'b0, nxt_cur_y} + 8'(GAP_H)));
    end

    // State, counters, captured coordinates and registered pixel outputs.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state   <= IDLE;
            row     <= 7'd0;
            col     <= '0;
            cur_x   <= 9'd0;
            cur_y   <= 7'd0;
            vga_x   <= 8'd0;
            vga_y   <= 7'd0;
            colour  <= 3'd0;
            plot    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state  <= nxt_state;
            row    <= nxt_row;
            col    <= nxt_col;
            cur_x  <= nxt_cur_x;
            cur_y  <= nxt_cur_y;
            vga_x  <= pix_on ? pix_col[7:0] : 8'd0;
            vga_y  <= pix_on ? nxt_row : 7'd0;
            plot   <= pix_on && (pix_col < 9'd160);
            busy   <= (nxt_state != IDLE);
            done   <= (nxt_state == DONE);
            if (!pix_on)
                colour <= 3'd0;
            else if (nxt_state == ERASE || in_gap)
                colour <= BG_COLOUR;
            else
                colour <= PIPE_COLOUR;
            if (tick && state != IDLE)
                overrun <= 1'b1;
        end
    end

`ifdef PIPE_DRAWER_ERASE_EN
    // Remember the finished column so the next redraw can erase it; reset forgets it.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            prev_x     <= 9'd0;
            prev_valid <= 1'b0;
        end else if (state == DONE) begin
            prev_x     <= cur_x;
            prev_valid <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_drawer.sv
// Purpose: randomized self-checking bench for pipe_drawer against a per-pixel expectation list.
// Latency: each redraw is followed pixel by pixel from the cycle busy rises to the done pulse.
// Backpressure: none in the DUT; extra game ticks are injected to exercise overrun.
module tb_pipe_drawer;

    localparam int         PIPE_W = 4;
    localparam int         GAP_H  = 30;
    localparam logic [2:0] PC     = 3'b010;
    localparam logic [2:0] BG     = 3'b000;
    localparam int         PIX    = 120 * PIPE_W;
`ifdef PIPE_DRAWER_ERASE_EN
    localparam bit ERASE_EN = 1'b1;
`else
    localparam bit ERASE_EN = 1'b0;
`endif

    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic       game_clk;
    logic [8:0] pipe_x;
    logic [6:0] pipe_y;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       done;
    logic       overrun;

    pipe_drawer #(
        .PIPE_W(PIPE_W), .GAP_H(GAP_H), .PIPE_COLOUR(PC), .BG_COLOUR(BG)
    ) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .game_clk(game_clk),
        .pipe_x(pipe_x), .pipe_y(pipe_y),
        .vga_x(vga_x), .vga_y(vga_y), .colour(colour), .plot(plot),
        .busy(busy), .done(done), .overrun(overrun)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: what the screen model remembers between redraws.
    bit          m_prev_valid = 1'b0;
    int          m_prev_x     = 0;
    logic [31:0] expq[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Word layout: busy, done, plot, colour, row, column low byte.
    function automatic logic [31:0] pix_word(input int column, input int r, input logic [2:0] c);
        logic [31:0] w;
        logic [8:0]  c9;
        c9       = column[8:0];
        w        = 32'd0;
        w[7:0]   = c9[7:0];
        w[14:8]  = r[6:0];
        w[17:15] = c;
        w[18]    = (column < 160);
        w[19]    = 1'b0;
        w[20]    = 1'b1;
        return w;
    endfunction

    function automatic logic [31:0] obs_word();
        return {11'd0, busy, done, plot, colour, vga_y, vga_x};
    endfunction

    task automatic build(input int x, input int y);
        expq.delete();
        if (ERASE_EN && m_prev_valid)
            for (int r = 0; r < 120; r++)
                for (int c = 0; c < PIPE_W; c++)
                    expq.push_back(pix_word(m_prev_x + c, r, BG));
        for (int r = 0; r < 120; r++)
            for (int c = 0; c < PIPE_W; c++)
                expq.push_back(pix_word(x + c, r, (r >= y && r < y + GAP_H) ? BG : PC));
    endtask

    // One game tick and the full redraw it should cause. ovr_at injects a second tick at that
    // pixel index; rst_at pulses reset at that pixel index and abandons the redraw.
    task automatic redraw(input int x, input int y, input int ovr_at, input int rst_at);
        int waited;
        build(x, y);
        pipe_x   = x[8:0];
        pipe_y   = y[6:0];
        game_clk = 1'b1;
        for (waited = 0; waited < 10 && busy !== 1'b1; waited++)
            @(negedge CLOCK_50);
        if (busy !== 1'b1) begin
            chk("busy_rise", {31'd0, busy}, 32'd1);
            game_clk = 1'b0;
            return;
        end
        game_clk = 1'b0;
        pipe_x   = 9'($urandom_range(0, 160));
        pipe_y   = 7'($urandom);
        for (int i = 0; i < expq.size(); i++) begin
            chk("pixel", obs_word(), expq[i]);
            if (i == rst_at) begin
                reset = 1'b1;
                @(negedge CLOCK_50);
                reset = 1'b0;
                chk("rst_mid", {4'd0, vga_x, vga_y, colour, plot, busy, done, overrun}, 32'd0);
                m_prev_valid = 1'b0;
                return;
            end
            if (i == ovr_at)     game_clk = 1'b1;
            if (i == ovr_at + 4) game_clk = 1'b0;
            @(negedge CLOCK_50);
        end
        chk("done_pulse", {29'd0, busy, done, plot}, 32'd6);
        @(negedge CLOCK_50);
        chk("busy_fall", {29'd0, busy, done, plot}, 32'd0);
        m_prev_valid = 1'b1;
        m_prev_x     = x;
    endtask

    initial begin
        int seen;
        reset    = 1'b1;
        game_clk = 1'b0;
        pipe_x   = 9'd0;
        pipe_y   = 7'd0;
        repeat (3) @(negedge CLOCK_50);
        chk("reset_vals", {4'd0, vga_x, vga_y, colour, plot, busy, done, overrun}, 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        chk("idle_vals", {4'd0, vga_x, vga_y, colour, plot, busy, done, overrun}, 32'd0);

        redraw(50, 40, -1, -1);
        redraw(49, 40, -1, -1);
        redraw(158, int'($urandom_range(0, 127)), -1, -1);
        redraw(0, int'($urandom_range(0, 127)), -1, -1);
        redraw(160, 90, -1, -1);

        // Extra tick mid-redraw: flagged, no second redraw, cleared by reset.
        redraw(int'($urandom_range(0, 160)), int'($urandom_range(0, 127)),
               (ERASE_EN ? PIX : 0) + 200, -1);
        chk("overrun_set", {31'd0, overrun}, 32'd1);
        seen = 0;
        repeat (30) begin
            @(negedge CLOCK_50);
            if (busy !== 1'b0) seen = 1;
        end
        chk("no_second_redraw", seen, 0);
        chk("overrun_sticky", {31'd0, overrun}, 32'd1);
        reset = 1'b1;
        @(negedge CLOCK_50);
        reset = 1'b0;
        m_prev_valid = 1'b0;
        chk("overrun_clr", {31'd0, overrun}, 32'd0);

        // Reset in the middle of DRAW; the following redraw must not erase.
        redraw(30, 10, -1, -1);
        redraw(70, 20, -1, ((ERASE_EN && m_prev_valid) ? PIX : 0) + 100);
        repeat (5) @(negedge CLOCK_50);
        redraw(80, 50, -1, -1);

        repeat (4)
            redraw(int'($urandom_range(0, 160)), int'($urandom_range(0, 127)), -1, -1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
